// File: rtl/tsu_pkg.sv
// Shared types and widths for the timestamp queue reader.
package tsu_pkg;

    localparam int TS_W    = 48;
    localparam int TAG_LSB = 32;
    localparam int STAT_W  = 8;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } tsu_state_e;

endpackage

// File: rtl/tsu_sat_cnt.sv
// Generic saturating up-counter; holds at all-ones instead of wrapping.
module tsu_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tsu_queue_reader.sv
// Pops tsu_queue entries one at a time into a valid/ready holding register.
// Define TSU_RD_CNT_EN to build the saturating delivered-entry counter on ts_cnt.
module tsu_queue_reader
    import tsu_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic              q_rd_clk,
    input  logic              q_rst_n,
    input  logic [STAT_W-1:0] q_rd_stat,
    input  logic [TS_W-1:0]   q_rd_data,
    output logic              q_rd_en,
    output logic              ts_valid,
    input  logic              ts_ready,
    output logic [TS_W-1:0]   ts_data,
    output logic [STAT_W-1:0] ts_pending,
    output logic [CNT_W-1:0]  ts_cnt,
    output tsu_state_e        dbg_state
);

    // Handshake: an entry moves on a cycle where ts_valid & ts_ready are both
    // high at the clock edge; ts_data is stable while ts_valid waits for ready.

    localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY - 1);

    tsu_state_e        state_q, state_d;
    logic              rd_en_q, rd_en_d;
    logic              valid_q, valid_d;
    logic [TS_W-1:0]   data_q, data_d;
    logic [STAT_W-1:0] pend_q, pend_d;
    logic [1:0]        lat_q, lat_d;

    always_comb begin
        state_d = state_q;
        rd_en_d = 1'b0;
        valid_d = valid_q;
        data_d  = data_q;
        pend_d  = q_rd_stat;
        lat_d   = lat_q;
        case (state_q)
            ST_IDLE: begin
                if (q_rd_stat != '0) begin
                    state_d = ST_POP;
                    rd_en_d = 1'b1;
                end
            end
            ST_POP: begin
                lat_d   = LAT_INIT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == 2'd0) begin
                    data_d  = q_rd_data;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            ST_HOLD: begin
                // Occupancy is only trusted here, long after the previous pop.
                if (valid_q && ts_ready) begin
                    valid_d = 1'b0;
                    if (q_rd_stat != '0) begin
                        state_d = ST_POP;
                        rd_en_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge q_rd_clk) begin
        if (!q_rst_n) begin
            state_q <= ST_IDLE;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            pend_q  <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_en_q <= rd_en_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            lat_q   <= lat_d;
        end
    end

    assign q_rd_en    = rd_en_q;
    assign ts_valid   = valid_q;
    assign ts_data    = data_q;
    assign ts_pending = pend_q;
    assign dbg_state  = state_q;

`ifdef TSU_RD_CNT_EN
    logic accept;
    assign accept = (state_q == ST_HOLD) && valid_q && ts_ready;

    tsu_sat_cnt #(
        .W(CNT_W)
    ) u_sat_cnt (
        .clk  (q_rd_clk),
        .rst_n(q_rst_n),
        .inc  (accept),
        .cnt  (ts_cnt)
    );
`else
    assign ts_cnt = '0;
`endif

endmodule

// File: tb/tb_tsu_queue_reader.sv
// Directed bench: latency-1 reader for reset/backpressure/reset-in-WAIT, latency-2 reader for streaming.
module tb_tsu_queue_reader;
    import tsu_pkg::*;

`ifdef TSU_RD_CNT_EN
    localparam logic CNT_EN = 1'b1;
`else
    localparam logic CNT_EN = 1'b0;
`endif

    logic clk;
    logic q_rst_n;

    logic [7:0]  stat_a, stat_b;
    logic [47:0] data_a, data_b;
    logic        rd_en_a, rd_en_b;
    logic        valid_a, valid_b;
    logic        ready_a, ready_b;
    logic [47:0] tsd_a, tsd_b;
    logic [7:0]  pend_a, pend_b;
    logic [15:0] cnt_a, cnt_b;
    tsu_state_e  dbg_a, dbg_b;

    int checks;
    int errors;

    // queue models
    logic [47:0] mem_a [0:15];
    logic [47:0] mem_b [0:15];
    int          total_a, total_b;
    int          ptr_a, ptr_b;
    int          idx_b;
    logic        pend_vld_b;

    // scoreboard
    logic [47:0] exp_qa[$];
    logic [47:0] exp_qb[$];
    logic [47:0] obs_qa[$];
    logic [47:0] obs_qb[$];
    int          del_a, del_b;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    tsu_queue_reader #(.RD_LATENCY(1)) dut_a (
        .q_rd_clk  (clk),
        .q_rst_n   (q_rst_n),
        .q_rd_stat (stat_a),
        .q_rd_data (data_a),
        .q_rd_en   (rd_en_a),
        .ts_valid  (valid_a),
        .ts_ready  (ready_a),
        .ts_data   (tsd_a),
        .ts_pending(pend_a),
        .ts_cnt    (cnt_a),
        .dbg_state (dbg_a)
    );

    tsu_queue_reader #(.RD_LATENCY(2)) dut_b (
        .q_rd_clk  (clk),
        .q_rst_n   (q_rst_n),
        .q_rd_stat (stat_b),
        .q_rd_data (data_b),
        .q_rd_en   (rd_en_b),
        .ts_valid  (valid_b),
        .ts_ready  (ready_b),
        .ts_data   (tsd_b),
        .ts_pending(pend_b),
        .ts_cnt    (cnt_b),
        .dbg_state (dbg_b)
    );

    assign stat_a = 8'(total_a - ptr_a);
    assign stat_b = 8'(total_b - ptr_b);

    // Latency-1 queue: data valid the cycle after the pop strobe.
    always @(posedge clk) begin
        if (rd_en_a) begin
            data_a <= mem_a[ptr_a];
            ptr_a  <= ptr_a + 1;
        end
    end

    // Latency-2 queue: data valid two cycles after the pop strobe.
    always @(posedge clk) begin
        pend_vld_b <= rd_en_b;
        if (rd_en_b) begin
            idx_b <= ptr_b;
            ptr_b <= ptr_b + 1;
        end
        if (pend_vld_b) data_b <= mem_b[idx_b];
    end

    // Record every handshake that the next rising edge will complete.
    always @(negedge clk) begin
        if (q_rst_n && valid_a && ready_a) begin
            obs_qa.push_back(tsd_a);
            del_a <= del_a + 1;
        end
        if (q_rst_n && valid_b && ready_b) begin
            obs_qb.push_back(tsd_b);
            del_b <= del_b + 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int last_pop;
        int npop;

        checks = 0; errors = 0;
        total_a = 5; total_b = 0;
        ptr_a = 0; ptr_b = 0; idx_b = 0; pend_vld_b = 1'b0;
        del_a = 0; del_b = 0;
        ready_a = 1'b0; ready_b = 1'b1;
        q_rst_n = 1'b0;

        mem_a[0] = 48'h0A0A_0000_0001;
        mem_a[1] = 48'h0A0B_0000_0010;
        mem_a[2] = 48'h0A0C_0000_0100;
        mem_a[3] = 48'h0A0D_0000_1000;
        mem_a[4] = 48'h0A0E_0001_0000;
        mem_a[5] = 48'hDEAD_DEAD_DEAD;
        mem_a[6] = 48'h0001_0000_1234;
        for (int i = 7; i < 16; i++) mem_a[i] = 48'h0;
        mem_b[0]  = 48'h1000_0000_0000;
        mem_b[1]  = 48'h1001_1111_1111;
        mem_b[2]  = 48'h1002_2222_2222;
        mem_b[3]  = 48'h1003_3333_3333;
        mem_b[4]  = 48'h1004_4444_4444;
        mem_b[5]  = 48'h1005_5555_5555;
        mem_b[6]  = 48'h1006_6666_6666;
        mem_b[7]  = 48'h1007_7777_7777;
        mem_b[8]  = 48'hFFFF_0000_0008;
        mem_b[9]  = 48'hFFFF_0000_0009;
        mem_b[10] = 48'hFFFF_0000_000A;
        for (int i = 11; i < 16; i++) mem_b[i] = 48'h0;

        // Reset held 3 cycles with nonzero occupancy.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_rd_en", 48'(rd_en_a), 48'd0);
            chk("rst_valid", 48'(valid_a), 48'd0);
            chk("rst_cnt",   48'(cnt_a),   48'd0);
        end
        chk("rst_data",  tsd_a,         48'h0);
        chk("rst_pend",  48'(pend_a),   48'd0);
        chk("rst_state", 48'(dbg_a),    48'(ST_IDLE));

        // First pop one cycle after release, then backpressure.
        q_rst_n = 1'b1;
        tick();
        chk("first_pop",  48'(rd_en_a), 48'd1);
        chk("first_pend", 48'(pend_a),  48'd5);
        tick();
        chk("pop_width",  48'(rd_en_a), 48'd0);
        chk("wait_valid", 48'(valid_a), 48'd0);
        for (int i = 0; i < 5; i++) exp_qa.push_back(mem_a[i]);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_valid", 48'(valid_a), 48'd1);
            chk("bp_data",  tsd_a,        mem_a[0]);
            chk("bp_no_pop", 48'(rd_en_a), 48'd0);
        end
        chk("bp_pops", 48'(ptr_a),  48'd1);
        chk("bp_pend", 48'(pend_a), 48'd4);
        ready_a = 1'b1;
        tick();
        chk("bp_release_pop",   48'(rd_en_a), 48'd1);
        chk("bp_release_valid", 48'(valid_a), 48'd0);
        chk("bp_release_cnt",   48'(cnt_a),   CNT_EN ? 48'd1 : 48'd0);
        for (int i = 0; i < 100 && !(del_a == 5 && !valid_a); i++) tick();
        chk("drain_a_done", 48'(del_a == 5 && !valid_a), 48'd1);
        chk("drain_a_cnt",  48'(cnt_a), CNT_EN ? 48'd5 : 48'd0);
        chk("drain_a_pops", 48'(ptr_a), 48'd5);

        // Reset while waiting for read data drops that entry.
        total_a = ptr_a + 1;
        for (int i = 0; i < 10 && !rd_en_a; i++) tick();
        chk("rw_pop", 48'(rd_en_a), 48'd1);
        tick();
        chk("rw_in_wait", 48'(dbg_a), 48'(ST_WAIT));
        q_rst_n = 1'b0;
        tick();
        chk("rw_valid0", 48'(valid_a), 48'd0);
        chk("rw_rd_en",  48'(rd_en_a), 48'd0);
        chk("rw_cnt",    48'(cnt_a),   48'd0);
        chk("rw_data",   tsd_a,        48'h0);
        tick();
        chk("rw_valid1", 48'(valid_a), 48'd0);

        // Single entry after release.
        total_a = ptr_a + 1;
        exp_qa.push_back(mem_a[6]);
        q_rst_n = 1'b1;
        tick();
        chk("single_pop",   48'(rd_en_a), 48'd1);
        tick();
        chk("single_wait",  48'(valid_a), 48'd0);
        tick();
        chk("single_valid", 48'(valid_a), 48'd1);
        chk("single_data",  tsd_a,        48'h0001_0000_1234);
        tick();
        chk("single_taken", 48'(valid_a), 48'd0);
        chk("single_cnt",   48'(cnt_a),   CNT_EN ? 48'd1 : 48'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("empty_pops",  48'(ptr_a),   48'd7);
        chk("empty_rd_en", 48'(rd_en_a), 48'd0);
        chk("empty_state", 48'(dbg_a),   48'(ST_IDLE));

        // Streaming 8 entries at latency 2: one pop every 4 cycles.
        for (int i = 0; i < 8; i++) exp_qb.push_back(mem_b[i]);
        total_b = 8;
        last_pop = -1;
        npop = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (rd_en_b) begin
                if (last_pop >= 0) chk("stream_spacing", 48'(c - last_pop), 48'd4);
                last_pop = c;
                npop++;
            end
        end
        chk("stream_pops", 48'(npop),  48'd8);
        chk("stream_del",  48'(del_b), 48'd8);
        chk("stream_cnt",  48'(cnt_b), CNT_EN ? 48'd8 : 48'd0);

        // Saturation of the delivered counter.
`ifdef TSU_RD_CNT_EN
        force dut_b.u_sat_cnt.cnt_q = 16'hFFFE;
        #1;
        release dut_b.u_sat_cnt.cnt_q;
        chk("sat_preload", 48'(cnt_b), 48'hFFFE);
`endif
        for (int i = 8; i < 11; i++) exp_qb.push_back(mem_b[i]);
        total_b = 11;
        for (int i = 0; i < 100 && !(del_b == 11 && !valid_b); i++) tick();
        chk("sat_done", 48'(del_b == 11 && !valid_b), 48'd1);
        chk("sat_cnt",  48'(cnt_b), CNT_EN ? 48'hFFFF : 48'd0);

        // Scoreboard compare: delivered data in order, nothing extra.
        while (exp_qa.size() > 0) begin
            if (obs_qa.size() == 0) begin
                chk("a_missing", 48'(exp_qa.size()), 48'd0);
                exp_qa.delete();
            end else begin
                chk("a_order", obs_qa.pop_front(), exp_qa.pop_front());
            end
        end
        chk("a_extra", 48'(obs_qa.size()), 48'd0);
        while (exp_qb.size() > 0) begin
            if (obs_qb.size() == 0) begin
                chk("b_missing", 48'(exp_qb.size()), 48'd0);
                exp_qb.delete();
            end else begin
                chk("b_order", obs_qb.pop_front(), exp_qb.pop_front());
            end
        end
        chk("b_extra", 48'(obs_qb.size()), 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tsu_queue_reader.md
# tsu_queue_reader

Drains timestamp entries from the `tsu_queue` read port and presents them one at a time on a valid/ready interface to the CPU-side register block. It sits directly downstream of `tsu_queue`, in the `q_rd_clk` domain, and owns the `q_rd_en` pop strobe. One entry is popped only when the output holding register is free, so no entry is ever lost except on reset.

## Interface
- `RD_LATENCY`, default 1: cycles from `q_rd_en` high to `q_rd_data` valid. Legal values are 1 or 2.
- `q_rd_clk` in, 1: the only clock.
- `q_rst_n` in, 1: synchronous, active-low reset.
- `q_rd_stat` in, 8: queue occupancy as an unsigned count; 0 means empty.
- `q_rd_data` in, 48: popped entry. `[47:32]` is the message tag, `[31:0]` is the timestamp.
- `q_rd_en` out, 1: pop strobe, one cycle per entry.
- `ts_valid` out, 1: `ts_data` holds an unconsumed entry.
- `ts_ready` in, 1: consumer accepts the entry this cycle.
- `ts_data` out, 48: held entry.
- `ts_pending` out, 8: registered copy of `q_rd_stat`.
- `ts_cnt` out, 16: count of entries delivered. Present only with `TSU_RD_CNT_EN`; otherwise driven to 0.

## Operation
- The FSM has four states: IDLE, POP, WAIT, HOLD.
- IDLE: when `q_rd_stat != 0`, go to POP.
- POP: `q_rd_en = 1` for exactly this cycle. Load the latency counter with `RD_LATENCY-1`. Go to WAIT.
- WAIT: decrement the counter. At 0, capture `q_rd_data` into `ts_data`, set `ts_valid`, and go to HOLD.
- HOLD: `ts_valid = 1` and `ts_data` is stable.
  - On `ts_valid & ts_ready`: clear `ts_valid` and increment `ts_cnt`.
  - Then go to POP if `q_rd_stat != 0`, else go to IDLE.
  - Without `ts_ready`: stay in HOLD indefinitely.
- `q_rd_en` is asserted only in POP. It is never asserted while `ts_valid = 1`.
- `q_rd_stat` is sampled only in IDLE and HOLD. By then at least `RD_LATENCY+1` cycles have passed since the last pop, so stale occupancy cannot cause a double pop.
- `ts_pending` is registered from `q_rd_stat` every cycle. It is informational only.
- `ts_cnt` saturates at 16'hFFFF and does not wrap.
- Reset values: state IDLE, `q_rd_en = 0`, `ts_valid = 0`, `ts_data = 48'h0`, `ts_pending = 8'h0`, `ts_cnt = 16'h0`.
- Reset during POP or WAIT drops the in-flight entry. This is accepted behaviour; the queue is reset by the same source.
- Reset during HOLD discards the held entry.
- `ts_ready` high while `ts_valid = 0` has no effect.

## Timing
- `q_rd_en` rises on the clock edge after IDLE sees nonzero stat: latency 1 from stat to pop.
- `ts_valid` rises `RD_LATENCY+1` cycles after the `q_rd_en` rising edge. With the default this is 2 cycles.
- Back-to-back throughput with `ts_ready` tied high is one entry per `RD_LATENCY+2` cycles: POP, WAIT×L, HOLD. With the default this is one entry every 3 cycles.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- `TSU_RD_CNT_EN`
  - Defined: the 16-bit saturating delivered counter is built and drives `ts_cnt`.
  - Undefined: the counter logic is omitted and `ts_cnt` is tied to 16'h0.
- FSM and handshake behaviour are identical in both builds.

## Structure
- Shared package `tsu_pkg` holds:
  - the state enum (IDLE/POP/WAIT/HOLD);
  - `TS_W = 48`, `TAG_LSB = 32`, `STAT_W = 8`, `CNT_W = 16`.
- Optional sub-module `tsu_sat_cnt`: a generic saturating up-counter, instantiated under `TSU_RD_CNT_EN`.
- Everything else stays in a single module.

## Test plan
- Reset: hold `q_rst_n = 0` for 3 cycles with `q_rd_stat = 5` -> `q_rd_en`, `ts_valid` and `ts_cnt` stay 0 throughout. The first `q_rd_en` appears 1 cycle after release.
- Single entry, `RD_LATENCY = 1`:
  - Stimulus: `q_rd_stat = 1`, `q_rd_data = 48'h0001_0000_1234`, `ts_ready = 1`.
  - Response: one `q_rd_en` pulse, `ts_valid` 2 cycles later with `ts_data = 48'h000100001234`, `ts_cnt = 1`.
  - Then with `q_rd_stat = 0`: no further pops.
- Backpressure: `ts_ready = 0` for 20 cycles with `q_rd_stat = 4` -> exactly one pop, and `ts_data` is stable for all 20 cycles. Raising `ts_ready` triggers the next pop on the following cycle.
- Streaming:
  - Stimulus: 8 entries with `RD_LATENCY = 2` and `ts_ready = 1`.
  - Response: 8 pops spaced 4 cycles apart, data delivered in order, `ts_cnt = 8`.
- Saturation (`TSU_RD_CNT_EN`): preload `ts_cnt` to 16'hFFFE via force and deliver 3 entries -> `ts_cnt` reads 16'hFFFF. Without the macro, `ts_cnt` is 0 throughout.
- Reset in WAIT: assert reset on the cycle after `q_rd_en` -> `ts_valid` never rises. After release, the next entry is popped normally.
